opcode_buffer: RTL and testbench
================================

// Module: opcode_buffer
// PURPOSE
// - Instruction-fetch front end: on request, reads one WORD_WIDTH-bit opcode starting at byte address ip.
// - Reads go through the byte-wide read port B of the SimpleMmu (ramData/ramBusy); this block drives that port's address.
// - Assembles the bytes and presents the opcode to the decoder.
// - busy falling edge marks the opcode as valid.
// PARAMETERS
// - ADDRESS_WIDTH  32  width of ip and of the memory byte address
// - WORD_WIDTH     32  opcode width; multiple of 8; BYTES = WORD_WIDTH/8
// PORTS
// - clk           in   1              single clock; all state changes on posedge
// - reset         in   1              asynchronous, active-high reset
// - ip            in   ADDRESS_WIDTH  byte address of the opcode to fetch
// - startLoading  in   1              level request to begin a fetch
// - ramData       in   8              byte from MMU port B for the current address
// - ramBusy       in   1              MMU port B busy; ramData invalid while high
// - busy          out  1              high while a fetch is in progress
// - opcode        out  WORD_WIDTH     assembled opcode; valid when busy is low after a fetch
// - address       out  ADDRESS_WIDTH  byte address driven to MMU port B
// BEHAVIOUR
// - Reset (async, any state):
//   - busy=0, opcode=0, address=0.
//   - Byte counter=0; FSM=IDLE.
// - FSM states: IDLE, ISSUE, WAIT, DONE (registered outputs throughout).
// - IDLE
//   - On posedge with startLoading=1: latch base=ip, clear counter i=0, busy<=1, go to ISSUE.
// - ISSUE
//   - address <= base+i (modulo 2^ADDRESS_WIDTH; wrap allowed).
//   - Go to WAIT.
//   - Address is then held stable until the byte is captured.
// - WAIT
//   - ramBusy=1: stay in WAIT, no capture.
//   - ramBusy=0: opcode[8*i+7:8*i] <= ramData (little-endian: byte at base+0 is opcode[7:0]).
//   - Last byte (i==BYTES-1): go to DONE.
//   - Otherwise: i<=i+1, go to ISSUE.
// - DONE
//   - busy<=0 and opcode is held; go to IDLE.
//   - busy is therefore low for at least one full cycle between fetches.
//   - If startLoading is still high in IDLE, a new fetch starts from the current ip.
//   - Each completed fetch produces one busy falling edge.
// - Latency
//   - Zero-wait memory: 2 cycles per byte, so BYTES*2+1 cycles from the start edge to busy falling (9 for 32-bit).
//   - Each ramBusy-high cycle in WAIT adds one cycle.
// - Mid-fetch inputs
//   - startLoading deassert: ignored; the fetch completes.
//   - ip change: ignored; base was latched.
// - opcode visibility
//   - Bytes are written in place, so opcode shows partial data while busy=1.
//   - Consumers sample opcode only when busy=0.
// - Reset mid-fetch: fetch aborted, reset values apply immediately, no partial opcode retained.
// - No write path: this block never writes memory.
// STRUCTURE
// - Shared package: FSM state encoding (IDLE/ISSUE/WAIT/DONE), default ADDRESS_WIDTH/WORD_WIDTH, BYTES derivation.
// - Single flat module; no sub-module.
// - Bench companion simple_mmu: byte RAM, two ports, busy/data per port.
// TESTING
// - Reset: reset=1 for 20 time units -> busy=0, opcode=0, address=0.
// - Basic fetch:
//   - Stimulus: mem[0..3]=11,22,33,44; ip=0; startLoading=1.
//   - Response: address visits 0,1,2,3; busy falls with opcode=0x44332211.
// - Wait states: ramBusy high 3 cycles per byte, mem[8..B]=DE,AD,BE,EF, ip=8
//   - Response: opcode=0xEFBEADDE.
//   - Busy duration is 9+12 cycles.
// - Wrap-around:
//   - Stimulus: ip=0xFFFFFFFE.
//   - Response: addresses FFFFFFFE, FFFFFFFF, 0, 1.
// - Latching / held request:
//   - Change ip from 0 to 4 mid-fetch: first fetch completes from 0.
//   - startLoading held high: busy low for 1 cycle, then refetch from 4; two busy falling edges seen.
// - Reset mid-fetch: assert reset after 2nd byte -> busy=0, opcode=0 at once; clean refetch after release.

Source files
------------

// File: rtl/opcode_buffer_pkg.sv
// Shared definitions for the instruction-fetch opcode buffer: FSM encoding,
// default geometry and the byte-count derivation.
package opcode_buffer_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 32;
    localparam int DEFAULT_WORD_WIDTH    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } fetchState_t;

    function automatic int bytesOf(input int wordWidth);
        return wordWidth / 8;
    endfunction

    // Counter width that can index every byte lane, never narrower than one bit.
    function automatic int laneIndexWidth(input int wordWidth);
        return (bytesOf(wordWidth) > 1) ? $clog2(bytesOf(wordWidth)) : 1;
    endfunction

endpackage

// File: rtl/opcode_buffer.sv
// Instruction-fetch front end: walks the bytes of one opcode through the MMU's
// byte-wide read port and assembles them little-endian for the decoder.
module opcode_buffer
    import opcode_buffer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] ip,
    input  logic                     startLoading,
    input  logic [7:0]               ramData,
    input  logic                     ramBusy,
    output logic                     busy,
    output logic [WORD_WIDTH-1:0]    opcode,
    output logic [ADDRESS_WIDTH-1:0] address
);

    localparam int BYTES = bytesOf(WORD_WIDTH);
    localparam int IDX_W = laneIndexWidth(WORD_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    fetchState_t              state;
    logic [ADDRESS_WIDTH-1:0] base;
    logic [IDX_W-1:0]         byteIdx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            opcode  <= '0;
            address <= '0;
            base    <= '0;
            byteIdx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (startLoading) begin
                        base    <= ip;
                        byteIdx <= '0;
                        busy    <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Address wraps naturally at the top of the address space.
                    address <= base + ADDRESS_WIDTH'(byteIdx);
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!ramBusy) begin
                        opcode[8*byteIdx +: 8] <= ramData;
                        if (byteIdx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            byteIdx <= byteIdx + 1'b1;
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    // Returning through IDLE guarantees one low busy cycle per fetch.
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opcode_buffer.sv
// Scoreboard bench for opcode_buffer with a behavioural byte-RAM read port
// that can insert wait states ahead of every byte.
module tb_opcode_buffer;

    typedef struct {
        logic [31:0] opcode;
        logic [31:0] base;
        int          cycles;
    } expFetch_t;

    localparam int WAIT_RELOAD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ip;
    logic        startLoading;
    logic [7:0]  ramData;
    logic        ramBusy;
    logic        busy;
    logic [31:0] opcode;
    logic [31:0] address;

    logic [7:0]  mem [0:255];
    logic        waitMode;
    int          waitCnt;

    int          checks;
    int          failures;
    int          fetchesSeen;
    int          lastLowRun;
    expFetch_t   expQ [$];

    opcode_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .ip           (ip),
        .startLoading (startLoading),
        .ramData      (ramData),
        .ramBusy      (ramBusy),
        .busy         (busy),
        .opcode       (opcode),
        .address      (address)
    );

    always #5 clk = ~clk;

    // MMU port B: combinational byte read, optional 3-cycle stall per byte.
    assign ramData = mem[address[7:0]];
    assign ramBusy = waitMode && (waitCnt != 0);

    always @(posedge clk) begin
        if (!busy && startLoading)
            waitCnt <= WAIT_RELOAD;
        else if (waitCnt != 0)
            waitCnt <= waitCnt - 1;
        else if (busy)
            waitCnt <= WAIT_RELOAD;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic waitFetches(input int target, input int budget);
        for (int c = 0; c < budget && fetchesSeen < target; c++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (fetchesSeen < target) begin
            failures++;
            $display("FAIL timeout fetches=%0d required=%0d", fetchesSeen, target);
        end
    endtask

    task automatic startFetch(input logic [31:0] addr);
        ip = addr;
        startLoading = 1'b1;
        @(posedge clk);
        #2;
        startLoading = 1'b0;
    endtask

    task automatic pushExp(input logic [31:0] op, input logic [31:0] b, input int cyc);
        expFetch_t e;
        e.opcode = op;
        e.base   = b;
        e.cycles = cyc;
        expQ.push_back(e);
    endtask

    // Monitor: traces addresses and busy length, scores each busy falling edge.
    initial begin
        logic        prevBusy;
        int          busyCycles;
        int          lowRun;
        logic [31:0] trace [$];
        expFetch_t   e;
        prevBusy   = 1'b0;
        busyCycles = 0;
        lowRun     = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevBusy   = 1'b0;
                busyCycles = 0;
                lowRun     = 0;
                trace.delete();
            end else begin
                if (busy) begin
                    if (!prevBusy) begin
                        lastLowRun = lowRun;
                        trace.delete();
                        busyCycles = 0;
                    end else if (trace.size() == 0 || trace[$] != address) begin
                        trace.push_back(address);
                    end
                    busyCycles++;
                end else begin
                    if (prevBusy) begin
                        fetchesSeen++;
                        lowRun = 0;
                        if (expQ.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_fetch opcode=%h required=none", opcode);
                        end else begin
                            e = expQ.pop_front();
                            check32("opcode", opcode, e.opcode);
                            check32("busy_cycles", busyCycles, e.cycles);
                            checks++;
                            if (trace.size() != 4) begin
                                failures++;
                                $display("FAIL addr_count actual=%0d required=4", trace.size());
                            end else begin
                                for (int k = 0; k < 4; k++) begin
                                    if (trace[k] !== e.base + k) begin
                                        failures++;
                                        $display("FAIL addr_seq[%0d] actual=%h required=%h",
                                                 k, trace[k], e.base + k);
                                        break;
                                    end
                                end
                            end
                        end
                    end
                    lowRun++;
                end
                prevBusy = busy;
            end
        end
    end

    initial begin
        checks       = 0;
        failures     = 0;
        fetchesSeen  = 0;
        lastLowRun   = 0;
        waitMode     = 1'b0;
        ip           = '0;
        startLoading = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
        mem[8'h04] = 8'h01; mem[8'h05] = 8'h02; mem[8'h06] = 8'h03; mem[8'h07] = 8'h04;
        mem[8'h08] = 8'hDE; mem[8'h09] = 8'hAD; mem[8'h0A] = 8'hBE; mem[8'h0B] = 8'hEF;
        mem[8'h10] = 8'hC0; mem[8'h11] = 8'hFF; mem[8'h12] = 8'hEE; mem[8'h13] = 8'h42;
        mem[8'hFE] = 8'hA5; mem[8'hFF] = 8'h5A;

        reset = 1'b1;
        #20;
        check32("reset_busy", busy, 32'd0);
        check32("reset_opcode", opcode, 32'h0);
        check32("reset_address", address, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;

        // Basic zero-wait fetch.
        pushExp(32'h44332211, 32'h0000_0000, 9);
        startFetch(32'h0000_0000);
        waitFetches(1, 60);

        // Three wait states per byte.
        waitMode = 1'b1;
        pushExp(32'hEFBEADDE, 32'h0000_0008, 21);
        startFetch(32'h0000_0008);
        waitFetches(2, 80);
        waitMode = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Address wrap at the top of memory.
        pushExp(32'h22115AA5, 32'hFFFF_FFFE, 9);
        startFetch(32'hFFFF_FFFE);
        waitFetches(3, 60);
        repeat (2) @(posedge clk);
        #2;

        // Held request with ip changing mid-fetch.
        pushExp(32'h44332211, 32'h0000_0000, 9);
        pushExp(32'h04030201, 32'h0000_0004, 9);
        ip = 32'h0000_0000;
        startLoading = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        ip = 32'h0000_0004;
        waitFetches(4, 60);
        startLoading = 1'b0;
        waitFetches(5, 60);
        check32("gap_cycles", lastLowRun, 32'd1);
        repeat (5) @(posedge clk);
        #2;
        check32("no_extra_fetch", busy, 32'd0);
        check32("fetch_total", fetchesSeen, 32'd5);

        // Reset after the second byte has been captured.
        startFetch(32'h0000_0010);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check32("midreset_busy", busy, 32'd0);
        check32("midreset_opcode", opcode, 32'h0);
        check32("midreset_address", address, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        pushExp(32'h42EEFFC0, 32'h0000_0010, 9);
        startFetch(32'h0000_0010);
        waitFetches(6, 60);
        check32("queue_drained", expQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
